// File: rtl/mmio_irq_controller_if.sv
// CPU data-bus and keyboard bundle for mmio_irq_controller.
// The CPU/bench side drives the access, the controller drives read data, enables and irq.
interface mmio_irq_controller_if;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        wr;
  logic        rd;
  logic [3:0]  wr_mask;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic [31:0] mrd;
  logic        mrd_valid;
  logic        ram_en;
  logic        vram_en;
  logic        irq;

  modport master (
    output addr_in, data_in, wr, rd, wr_mask, kbd_valid, kbd_data,
    input  mrd, mrd_valid, ram_en, vram_en, irq
  );

  modport slave (
    input  addr_in, data_in, wr, rd, wr_mask, kbd_valid, kbd_data,
    output mrd, mrd_valid, ram_en, vram_en, irq
  );
endinterface

// File: rtl/mmio_irq_controller.sv
// Memory-mapped IO decoder with ms counter, keyboard FIFO, periodic timers and
// an interrupt pending/enable controller; IO reads return one cycle after rd.
module mmio_irq_controller #(
  parameter int unsigned N_TIMERS    = 2,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CLK_PER_MS  = 50000,
  parameter logic [3:0]  RAM_REGION  = 4'h0,
  parameter logic [3:0]  VRAM_REGION = 4'h8,
  parameter logic [3:0]  IO_REGION   = 4'hF
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_irq_controller_if.slave  bus
);

  localparam int unsigned NP = N_TIMERS + 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  localparam logic [7:0] OFF_MS       = 8'h00;
  localparam logic [7:0] OFF_KBD_DATA = 8'h04;
  localparam logic [7:0] OFF_KBD_STAT = 8'h08;
  localparam logic [7:0] OFF_PEND     = 8'h0C;
  localparam logic [7:0] OFF_EN       = 8'h10;

  function automatic logic [7:0] tmr_off(input int unsigned i);
    return 8'(32'h20 + 8 * i);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   ms_q, ms_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   load_q [N_TIMERS];
  logic [31:0]   load_d [N_TIMERS];
  logic [31:0]   cnt_q  [N_TIMERS];
  logic [31:0]   cnt_d  [N_TIMERS];
  logic [NP-1:0] pend_q, pend_d, en_q, en_d;
  logic [31:0]   mrd_q, mrd_d;
  logic          mrd_valid_q, mrd_valid_d;
  logic          irq_q, irq_d;

  logic [3:0]    region;
  logic [7:0]    off;
  logic          io_hit, rd_io, wr_io;
  logic [31:0]   bmask;
  logic          tick, empty, full, pop_ok, push_ok;
  logic [NP-1:0] hw_set, sw_clr;
  logic [31:0]   rdata;
  logic          unused_addr;

  assign region      = bus.addr_in[31:28];
  assign off         = {bus.addr_in[7:2], 2'b00};
  assign io_hit      = (region == IO_REGION);
  assign rd_io       = bus.rd & io_hit;
  assign wr_io       = bus.wr & io_hit;
  assign bus.ram_en  = bus.wr & (region == RAM_REGION);
  assign bus.vram_en = bus.wr & (region == VRAM_REGION);
  assign bmask       = {{8{bus.wr_mask[3]}}, {8{bus.wr_mask[2]}},
                        {8{bus.wr_mask[1]}}, {8{bus.wr_mask[0]}}};
  assign unused_addr = ^{bus.addr_in[27:8], bus.addr_in[1:0]};

  assign tick    = (presc_q == PW'(CLK_PER_MS - 1));
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop_ok  = rd_io && (off == OFF_KBD_DATA) && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = bus.kbd_valid && (!full || pop_ok);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    ms_d    = ms_q + 32'(tick);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    ovf_d   = ovf_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    hw_set  = '0;
    sw_clr  = '0;

    if (push_ok) begin
      mem_d[wptr_q] = bus.kbd_data;
      wptr_d        = wptr_q + AW'(1);
      hw_set[0]     = 1'b1;
    end
    if (pop_ok) rptr_d = rptr_q + AW'(1);
    if (wr_io && (off == OFF_KBD_STAT)) ovf_d = 1'b0;
    if (bus.kbd_valid && !push_ok)      ovf_d = 1'b1;

    // A LOAD write takes priority over a coincident tick and suppresses its event.
    for (int i = 0; i < N_TIMERS; i++) begin
      if (wr_io && (off == tmr_off(i))) begin
        load_d[i] = merge_bytes(load_q[i], bus.data_in, bmask);
        cnt_d[i]  = merge_bytes(load_q[i], bus.data_in, bmask);
      end else if (tick) begin
        if (load_q[i] == '0) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] > 32'd1) begin
          cnt_d[i] = cnt_q[i] - 32'd1;
        end else begin
          cnt_d[i] = load_q[i];
          if (cnt_q[i] == 32'd1) hw_set[i+1] = 1'b1;
        end
      end
    end

    if (wr_io && (off == OFF_PEND)) sw_clr = NP'(bus.data_in & bmask);
    if (wr_io && (off == OFF_EN))   en_d   = NP'(merge_bytes(32'(en_q), bus.data_in, bmask));
    pend_d = (pend_q & ~sw_clr) | hw_set;
    irq_d  = |(pend_q & en_q);
  end

  // Read mux always reflects pre-write state.
  always_comb begin
    case (off)
      OFF_MS:       rdata = ms_q;
      OFF_KBD_DATA: rdata = {23'b0, ~empty, empty ? 8'h00 : mem_q[rptr_q]};
      OFF_KBD_STAT: rdata = {16'b0, ovf_q, full, empty, 5'b0, 8'(count_q)};
      OFF_PEND:     rdata = 32'(pend_q);
      OFF_EN:       rdata = 32'(en_q);
      default:      rdata = '0;
    endcase
    for (int i = 0; i < N_TIMERS; i++) begin
      if (off == tmr_off(i))          rdata = load_q[i];
      if (off == tmr_off(i) + 8'h04)  rdata = cnt_q[i];
    end
    mrd_d       = rd_io ? rdata : mrd_q;
    mrd_valid_d = rd_io;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q     <= '0;
      ms_q        <= '0;
      mem_q       <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      load_q      <= '{default: '0};
      cnt_q       <= '{default: '0};
      pend_q      <= '0;
      en_q        <= '0;
      mrd_q       <= '0;
      mrd_valid_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      load_q      <= load_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      mrd_q       <= mrd_d;
      mrd_valid_q <= mrd_valid_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.mrd       = mrd_q;
  assign bus.mrd_valid = mrd_valid_q;
  assign bus.irq       = irq_q;

endmodule

// File: doc/mmio_irq_controller.md
Name: mmio_irq_controller

Overview:
Parametrised memory-mapped I/O controller that replaces the fixed single-peripheral decoder. It decodes CPU data-bus accesses into RAM, VRAM and IO regions, and hosts the following IO registers:
- free-running millisecond counter
- keyboard scan-code FIFO
- N periodic down-count timers
- interrupt pending/enable controller driving the CPU irq line

Reads are registered (1-cycle latency).

Parameters:
- N_TIMERS, 2: number of periodic timer channels (1..8)
- FIFO_DEPTH, 8: keyboard FIFO entries, power of two (2..64)
- CLK_PER_MS, 50000: clk cycles per millisecond tick
- RAM_REGION, 4'h0: addr_in[31:28] value selecting RAM
- VRAM_REGION, 4'h8: addr_in[31:28] value selecting video RAM
- IO_REGION, 4'hF: addr_in[31:28] value selecting these registers

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- addr_in  in  32  byte address from CPU
- data_in  in  32  write data
- wr  in  1  write strobe, one cycle per access
- rd  in  1  read strobe, one cycle per access
- wr_mask  in  4  byte enables for writes; bit i covers data_in[8i+7:8i]
- kbd_valid  in  1  one-cycle pulse: new scan code available
- kbd_data  in  8  scan code / ASCII byte
- mrd  out  32  registered IO read data
- mrd_valid  out  1  high one cycle after an IO-region rd
- ram_en  out  1  combinational: wr & (addr_in[31:28]==RAM_REGION)
- vram_en  out  1  combinational: wr & (addr_in[31:28]==VRAM_REGION)
- irq  out  1  registered: |(pending & enable)

Behaviour:
- Clock and reset: single clock domain. reset low at a clk edge clears:
  - all counters, FIFO pointers, count and overflow
  - pending, enable and timer LOAD/COUNT
  - mrd, mrd_valid and irq, which read 0 in the following cycle
  - Reset mid-access aborts the access; no side effects.
- IO register decode: an access hits IO only when addr_in[31:28]==IO_REGION. Offset = addr_in[7:0], word aligned; addr_in[1:0] ignored.
  - 0x00 MS (RO): increments when the prescaler reaches CLK_PER_MS-1; prescaler then restarts at 0. Wraps 0xFFFFFFFF->0.
  - 0x04 KBD_DATA (RO, pop on read): mrd={23'b0, valid, data}. Empty: valid=0, data=0, no pointer change.
  - 0x08 KBD_STATUS: mrd={16'b0, overflow, full, empty, 5'b0, count[7:0]}. Any write clears overflow.
  - 0x0C IRQ_PENDING: bit0 keyboard, bit(i+1) timer i. Write-1-to-clear, masked by wr_mask.
  - 0x10 IRQ_ENABLE (RW, byte-masked): only bits 0..N_TIMERS are writable; other bits read 0.
  - 0x20+8i TIMERi_LOAD (RW): a write loads COUNT from the newly written value in the next cycle.
  - 0x24+8i TIMERi_COUNT (RO).
  - Unmapped offsets read 0; writes to them are ignored.
- Reads: mrd/mrd_valid are registered on the cycle after rd. mrd holds its value until the next IO read.
  - rd and wr asserted together: the write takes effect; the read returns the pre-write value.
- FIFO push (kbd_valid):
  - Not full: store the byte. If pending bit0 is clear, set it.
  - Full: drop the byte and set sticky overflow.
  - Push and pop in the same cycle when neither full nor empty: both occur, count unchanged.
  - Push and pop in the same cycle when full: the pop frees a slot and the push is accepted.
  - Push and pop in the same cycle when empty: the pop returns valid=0 and the push is accepted.
- Timers, per channel, on each ms tick:
  - LOAD==0: timer disabled, COUNT held at 0.
  - COUNT>1: decrement COUNT.
  - COUNT==1: set pending bit(i+1) and reload COUNT=LOAD, giving a periodic interval of LOAD ms.
  - A LOAD write coincident with a tick: the write wins and no event fires.
- Pending set and clear: a hardware set and a software W1C on the same bit in the same cycle leave the bit set.
- irq: asserted the cycle after (pending & enable) becomes nonzero.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with random bus traffic -> mrd=0, mrd_valid=0, irq=0; a read of 0x0C returns 0.
2. FIFO fill and overflow, FIFO_DEPTH=8: push 9 codes 0x41..0x49, then read STATUS -> count=8, full=1, overflow=1. Eight pops return 0x141..0x148 (valid bit set); a ninth pop returns 0x000.
3. Simultaneous push and pop: with count=3, pulse kbd_valid together with a pop -> count stays 3, and FIFO order is preserved.
4. Timer periodic IRQ, CLK_PER_MS=4:
   - write 0x10=0x2, then LOAD0=3 -> pending bit1 sets every 12 cycles ±1, and irq rises the next cycle;
   - W1C 0x0C=0x2 -> irq drops the cycle after clear;
   - a coincident set wins.
5. Decode and masks:
   - wr to 0x0000_0100 -> ram_en=1, vram_en=0;
   - wr to 0x8000_0000 -> vram_en=1;
   - write IRQ_ENABLE=0xFFFFFFFF with wr_mask=4'b0001 -> readback 0x7 (N_TIMERS=2).
6. MS wrap and unmapped offset: force MS to 0xFFFFFFFF, then one tick -> reads 0; a read of unmapped offset 0x18 -> 0 with mrd_valid=1.
